// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller:
// coin encodings, coin values, controller states and the coin value helper.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    localparam logic [4:0] VAL_5  = 5'd5;
    localparam logic [4:0] VAL_10 = 5'd10;
    localparam logic [4:0] VAL_20 = 5'd20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_CHANGE = 2'd2
    } vend_state_e;

    function automatic logic [4:0] coin_value(input logic [1:0] coin);
        logic [4:0] val;
        case (coin)
            COIN_5:  val = VAL_5;
            COIN_10: val = VAL_10;
            COIN_20: val = VAL_20;
            default: val = 5'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item saturating stock counters with vend decrement and restock add,
// plus a registered sold-out vector.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8,
    localparam int ISEL_W    = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_valid,
    input  logic [ISEL_W-1:0]    dec_item,
    input  logic                 restock_valid,
    input  logic [ISEL_W-1:0]    restock_item,
    input  logic [STOCK_W-1:0]   restock_qty,
    output logic [NUM_ITEMS-1:0] avail,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam logic [STOCK_W:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
        logic [STOCK_W-1:0] stock;
        logic [STOCK_W:0]   sum;
        logic               dec_hit;
        logic               add_hit;

        assign dec_hit = dec_valid && (dec_item == ISEL_W'(i));
        assign add_hit = restock_valid && (restock_item == ISEL_W'(i));

        // A decrement is only issued when stock is nonzero, so the
        // combined add-then-subtract cannot underflow; only the top clips.
        always_comb begin
            sum = {1'b0, stock};
            if (add_hit) sum = sum + {1'b0, restock_qty};
            if (dec_hit) sum = sum - (STOCK_W+1)'(1);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                stock <= STOCK_W'(INIT_STOCK);
            end else begin
                stock <= (sum > STOCK_MAX) ? STOCK_MAX[STOCK_W-1:0] : sum[STOCK_W-1:0];
            end
        end

        assign avail[i] = (stock != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sold_out <= {NUM_ITEMS{INIT_STOCK == 0}};
        end else begin
            sold_out <= ~avail;
        end
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit accumulation, product selection,
// stock tracking and greedy single-coin change/refund over valid/ack.
//
// state     | meaning
// ST_IDLE   | credit is zero, waiting for the first coin
// ST_ACCUM  | credit > 0, accepting coins, selections and cancel
// ST_CHANGE | paying out credit one coin at a time
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W  = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {8'd20, 8'd15, 8'd10, 8'd15},
    parameter int MAX_CREDIT = 50,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 8,
    localparam int ISEL_W    = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           coin_in,
    input  logic                 sel_valid,
    input  logic [ISEL_W-1:0]    sel_item,
    input  logic                 cancel,
    input  logic                 restock_valid,
    input  logic [ISEL_W-1:0]    restock_item,
    input  logic [STOCK_W-1:0]   restock_qty,
    input  logic                 change_ack,
    output logic                 vend_valid,
    output logic [ISEL_W-1:0]    vend_item,
    output logic                 change_valid,
    output logic [1:0]           change_coin,
    output logic                 coin_reject,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out
);

    vend_state_e         state, state_next;
    logic [CREDIT_W-1:0] credit_next;
    logic                vend_next;
    logic                reject_next;

    logic [CREDIT_W-1:0] price_arr [NUM_ITEMS];
    logic [CREDIT_W-1:0] price_sel;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] remainder;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_fits;
    logic                coin_present;
    logic                item_ok;
    logic                sel_ok;
    logic                cancel_ok;
    logic [1:0]          greedy_coin;
    logic [NUM_ITEMS-1:0] stock_avail;

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
        assign price_arr[i] = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
    end

    always_comb begin
        coin_present = (coin_in != COIN_NONE);
        coin_val     = CREDIT_W'(coin_value(coin_in));
        credit_sum   = {1'b0, credit} + {1'b0, coin_val};
        coin_fits    = (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
        item_ok      = (32'(sel_item) < NUM_ITEMS);
        price_sel    = item_ok ? price_arr[sel_item] : '0;
        remainder    = credit - price_sel;
        // Stock check uses the pre-update counter, so a same-cycle restock
        // cannot make an empty item vendable.
        sel_ok       = (state == ST_ACCUM) && sel_valid && item_ok &&
                       stock_avail[sel_item] && (credit >= price_sel);
        cancel_ok    = (state == ST_ACCUM) && cancel;
    end

    always_comb begin
        if (credit >= CREDIT_W'(VAL_20)) begin
            greedy_coin = COIN_20;
        end else if (credit >= CREDIT_W'(VAL_10)) begin
            greedy_coin = COIN_10;
        end else if (credit >= CREDIT_W'(VAL_5)) begin
            greedy_coin = COIN_5;
        end else begin
            greedy_coin = COIN_NONE;
        end
    end

    always_comb begin
        state_next  = state;
        credit_next = credit;
        vend_next   = 1'b0;
        reject_next = 1'b0;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (cancel_ok) begin
                    state_next  = ST_CHANGE;
                    reject_next = coin_present;
                end else if (sel_ok) begin
                    credit_next = remainder;
                    vend_next   = 1'b1;
                    reject_next = coin_present;
                    state_next  = (remainder != '0) ? ST_CHANGE : ST_IDLE;
                end else if (coin_present) begin
                    if (coin_fits) begin
                        credit_next = credit_sum[CREDIT_W-1:0];
                        state_next  = ST_ACCUM;
                    end else begin
                        reject_next = 1'b1;
                    end
                end
            end
            ST_CHANGE: begin
                reject_next = coin_present;
                if (change_ack) begin
                    credit_next = credit - CREDIT_W'(coin_value(greedy_coin));
                    if (credit_next == '0) state_next = ST_IDLE;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                credit_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            credit      <= '0;
            vend_valid  <= 1'b0;
            vend_item   <= '0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_next;
            credit      <= credit_next;
            vend_valid  <= vend_next;
            vend_item   <= sel_ok ? sel_item : '0;
            coin_reject <= reject_next;
        end
    end

    assign change_valid = (state == ST_CHANGE);
    assign change_coin  = (state == ST_CHANGE) ? greedy_coin : COIN_NONE;

    vend_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk           (clk),
        .reset         (reset),
        .dec_valid     (sel_ok),
        .dec_item      (sel_item),
        .restock_valid (restock_valid),
        .restock_item  (restock_item),
        .restock_qty   (restock_qty),
        .avail         (stock_avail),
        .sold_out      (sold_out)
    );

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi; prices set so item0=20, item1=15,
// item2=10, item3=15 (item0 in the LSBs of PRICE_LIST).
module tb_vend_ctrl_multi;

    localparam logic [1:0] C5  = 2'b01;
    localparam logic [1:0] C10 = 2'b10;
    localparam logic [1:0] C20 = 2'b11;

    logic       clk;
    logic       reset;
    logic [1:0] coin_in;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       restock_valid;
    logic [1:0] restock_item;
    logic [3:0] restock_qty;
    logic       change_ack;
    logic       vend_valid;
    logic [1:0] vend_item;
    logic       change_valid;
    logic [1:0] change_coin;
    logic       coin_reject;
    logic [7:0] credit;
    logic [3:0] sold_out;

    int vectors = 0;
    int errors  = 0;

    vend_ctrl_multi #(
        .NUM_ITEMS  (4),
        .CREDIT_W   (8),
        .PRICE_LIST ({8'd15, 8'd10, 8'd15, 8'd20}),
        .MAX_CREDIT (50),
        .STOCK_W    (4),
        .INIT_STOCK (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_in       (coin_in),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel        (cancel),
        .restock_valid (restock_valid),
        .restock_item  (restock_item),
        .restock_qty   (restock_qty),
        .change_ack    (change_ack),
        .vend_valid    (vend_valid),
        .vend_item     (vend_item),
        .change_valid  (change_valid),
        .change_coin   (change_coin),
        .coin_reject   (coin_reject),
        .credit        (credit),
        .sold_out      (sold_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin_in = c;
        tick();
        coin_in = 2'b00;
    endtask

    task automatic do_sel(input logic [1:0] item);
        sel_valid = 1'b1;
        sel_item  = item;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic buy_item3(input string tag);
        put_coin(C10);
        put_coin(C5);
        do_sel(2'd3);
        chk(tag, {31'd0, vend_valid}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; coin_in = 2'b00; sel_valid = 1'b0; sel_item = 2'd0;
        cancel = 1'b0; restock_valid = 1'b0; restock_item = 2'd0;
        restock_qty = 4'd0; change_ack = 1'b0;
        tick(); tick();
        chk("rst_credit",   32'(credit), 32'd0);
        chk("rst_chg_vld",  32'(change_valid), 32'd0);
        chk("rst_chg_coin", 32'(change_coin), 32'd0);
        chk("rst_vend",     32'(vend_valid), 32'd0);
        chk("rst_reject",   32'(coin_reject), 32'd0);
        chk("rst_sold_out", 32'(sold_out), 32'd0);
        reset = 1'b0;

        // Exact payment for item1 (15)
        put_coin(C10);
        chk("t1_credit10", 32'(credit), 32'd10);
        put_coin(C5);
        chk("t1_credit15", 32'(credit), 32'd15);
        do_sel(2'd1);
        chk("t1_vend",     32'(vend_valid), 32'd1);
        chk("t1_item",     32'(vend_item), 32'd1);
        chk("t1_credit0",  32'(credit), 32'd0);
        chk("t1_no_chg",   32'(change_valid), 32'd0);
        tick();
        chk("t1_vend_off", 32'(vend_valid), 32'd0);

        // 40 credit, item2 (10) -> change 20 then 10
        put_coin(C20);
        put_coin(C20);
        chk("t2_credit40", 32'(credit), 32'd40);
        do_sel(2'd2);
        chk("t2_vend",     32'(vend_valid), 32'd1);
        chk("t2_item",     32'(vend_item), 32'd2);
        chk("t2_credit30", 32'(credit), 32'd30);
        chk("t2_chg_vld",  32'(change_valid), 32'd1);
        chk("t2_coin20",   32'(change_coin), 32'(C20));
        change_ack = 1'b1;
        tick();
        chk("t2_credit10", 32'(credit), 32'd10);
        chk("t2_coin10",   32'(change_coin), 32'(C10));
        tick();
        chk("t2_credit0",  32'(credit), 32'd0);
        chk("t2_chg_done", 32'(change_valid), 32'd0);
        change_ack = 1'b0;

        // Credit ceiling, over-limit reject, refund with stalled hopper
        put_coin(C20);
        put_coin(C20);
        put_coin(C10);
        chk("t3_credit50", 32'(credit), 32'd50);
        put_coin(C5);
        chk("t3_reject",   32'(coin_reject), 32'd1);
        chk("t3_credit_keep", 32'(credit), 32'd50);
        tick();
        chk("t3_reject_off", 32'(coin_reject), 32'd0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t3_chg_vld",  32'(change_valid), 32'd1);
        chk("t3_refund_credit", 32'(credit), 32'd50);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_coin", 32'(change_coin), 32'(C20));
            chk("t3_hold_credit", 32'(credit), 32'd50);
            tick();
        end
        change_ack = 1'b1;
        tick();
        chk("t3_credit30", 32'(credit), 32'd30);
        chk("t3_coin20b",  32'(change_coin), 32'(C20));
        tick();
        chk("t3_credit10", 32'(credit), 32'd10);
        chk("t3_coin10",   32'(change_coin), 32'(C10));
        tick();
        chk("t3_credit0",  32'(credit), 32'd0);
        chk("t3_chg_done", 32'(change_valid), 32'd0);
        change_ack = 1'b0;

        // Underpaid selection, then selection with simultaneous coin
        put_coin(C5);
        do_sel(2'd0);
        chk("t4_no_vend",  32'(vend_valid), 32'd0);
        chk("t4_credit5",  32'(credit), 32'd5);
        put_coin(C10);
        chk("t4_credit15", 32'(credit), 32'd15);
        coin_in = C5;
        do_sel(2'd1);
        coin_in = 2'b00;
        chk("t4_vend",     32'(vend_valid), 32'd1);
        chk("t4_item",     32'(vend_item), 32'd1);
        chk("t4_coin_rej", 32'(coin_reject), 32'd1);
        chk("t4_credit0",  32'(credit), 32'd0);

        // Drain item3 stock of 8
        for (int i = 0; i < 8; i++) buy_item3("t5_drain_vend");
        tick();
        chk("t5_sold_out", 32'(sold_out), 32'h8);
        put_coin(C10);
        put_coin(C5);
        do_sel(2'd3);
        chk("t5_empty_no_vend", 32'(vend_valid), 32'd0);
        chk("t5_empty_credit",  32'(credit), 32'd15);

        // Restock 15 then 5: must clip at 15, not wrap to 4
        restock_valid = 1'b1;
        restock_item  = 2'd3;
        restock_qty   = 4'd15;
        tick();
        restock_qty   = 4'd5;
        tick();
        restock_valid = 1'b0;
        restock_qty   = 4'd0;
        tick();
        chk("t5_restocked", 32'(sold_out), 32'h0);
        do_sel(2'd3);
        chk("t5_vend_after_restock", 32'(vend_valid), 32'd1);
        for (int i = 0; i < 13; i++) buy_item3("t5_sat_vend");
        tick();
        chk("t5_one_left", 32'(sold_out), 32'h0);
        buy_item3("t5_last_vend");
        tick();
        chk("t5_sold_again", 32'(sold_out), 32'h8);

        // Reset during refund
        put_coin(C20);
        put_coin(C10);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t6_chg_vld",  32'(change_valid), 32'd1);
        chk("t6_credit30", 32'(credit), 32'd30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_credit0",  32'(credit), 32'd0);
        chk("t6_chg_off",  32'(change_valid), 32'd0);
        chk("t6_sold_out", 32'(sold_out), 32'h0);
        buy_item3("t6_stock_restored");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised multi-product vending controller.
- Accumulates credit from 5/10/20 coins and vends one of NUM_ITEMS products at per-item prices.
- Tracks per-item stock with restock, and returns change or refunds as a stream of single coins over a valid/ack handshake.
- Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

Parameters:
- NUM_ITEMS, 4, number of products (min 2).
- CREDIT_W, 8, credit/price width in money units.
- PRICE_LIST, {8'd20,8'd15,8'd10,8'd15}, packed NUM_ITEMS*CREDIT_W prices, item0 in LSBs. Each price must be a nonzero multiple of 5.
- MAX_CREDIT, 50, credit ceiling (multiple of 5, < 2**CREDIT_W).
- STOCK_W, 4, per-item stock counter width.
- INIT_STOCK, 8, stock loaded into every item at reset.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- coin_in  in  2  00 none, 01 =5, 10 =10, 11 =20; one coin per cycle.
- sel_valid  in  1  product selection strobe.
- sel_item  in  ISEL_W  selected item index, ISEL_W = $clog2(NUM_ITEMS).
- cancel  in  1  refund request.
- restock_valid  in  1  restock strobe.
- restock_item  in  ISEL_W  item to restock.
- restock_qty  in  STOCK_W  quantity to add.
- change_ack  in  1  hopper accepted current change coin.
- vend_valid  out  1  one-cycle dispense pulse.
- vend_item  out  ISEL_W  item dispensed; valid with vend_valid.
- change_valid  out  1  change coin pending.
- change_coin  out  2  coin to emit, same encoding as coin_in.
- coin_reject  out  1  one-cycle pulse: coin returned unaccepted.
- credit  out  CREDIT_W  current credit.
- sold_out  out  NUM_ITEMS  bit i = stock[i]==0.

Behaviour:
- Reset: state IDLE; all outputs 0 except sold_out (0 unless INIT_STOCK==0); every stock counter = INIT_STOCK. Reset mid-operation discards credit and any pending change.
- States:
  - IDLE: credit==0.
  - ACCUM: credit>0, accepting coins and selections.
  - CHANGE: emitting coins.
- Coin handling (IDLE/ACCUM):
  - Coin is accepted if credit+value <= MAX_CREDIT; credit updates at the next edge, and IDLE->ACCUM.
  - Otherwise coin_reject pulses the next cycle and credit is unchanged.
- Coin in CHANGE, or in the same cycle as an accepted sel/cancel: rejected (coin_reject next cycle).
- Priority within a cycle: cancel > sel_valid > coin_in.
- Selection is accepted only in ACCUM when sel_item < NUM_ITEMS, stock[sel_item] > 0 and credit >= price. Next cycle:
  - vend_valid=1, vend_item=sel_item.
  - credit -= price; stock[sel_item] -= 1.
  - State -> CHANGE if remainder > 0, else IDLE.
- Rejected selection: silently ignored; credit and state unchanged. No dispense can occur without full payment.
- Cancel:
  - ACCUM -> CHANGE with credit intact.
  - In IDLE: no effect.
  - In CHANGE: no effect; change already in progress.
- CHANGE:
  - change_valid=1; change_coin = largest of 20/10/5 <= credit (greedy).
  - On change_valid & change_ack: credit -= coin value at that edge.
  - When credit reaches 0: state -> IDLE and change_valid=0 from the next cycle. Without ack, change_coin is held stable.
- Restock accepted in any state. stock = min(stock + qty, 2**STOCK_W-1).
- Restock and vend of the same item in one cycle: net result = sat(stock - 1 + qty). The selection check uses the pre-update stock.
- sold_out is registered from the stock counters, so it reflects updated stock one cycle after the change.
- Invariant: credit is always a multiple of 5 and <= MAX_CREDIT.
- Latency:
  - Coin -> credit: 1 cycle.
  - sel -> vend_valid: 1 cycle.
  - Ack -> next coin: 1 cycle.

Decomposition:
- Package vend_pkg: coin encodings, coin values (5/10/20), state enum (IDLE/ACCUM/CHANGE), and function coin_value().
- Sub-module vend_stock_bank: NUM_ITEMS saturating counters handling decrement/restock, plus the sold_out vector.
- The FSM, credit register and greedy change selection live in the top level.

Test Plan:
- Coins 10,5 then sel item1 (price 15) -> vend_valid with vend_item=1 one cycle after sel; credit 0; state IDLE; no change_valid.
- Coins 20,20 then sel item2 (10) -> vend; then change_coin=20 (ack), 10 (ack); change_valid drops; credit 0.
- Coins 20,20,10 then coin 5 -> credit 50, 5 rejected (coin_reject pulse); cancel with change_ack held low 3 cycles -> change_coin=20 stable, then 20, 20, 10 after acks.
- Coin 5 then sel item0 (20) -> no vend, credit stays 5. Simultaneous sel and coin with enough credit -> vend, and the coin is rejected.
- Vend item3 eight times (INIT_STOCK=8) -> sold_out[3]=1; next sel item3 ignored. Restock item3 qty 20 -> stock saturates at 15, sold_out[3]=0.
- Reset asserted in CHANGE with credit 30 -> next cycle credit 0, change_valid 0, all stock back to 8.
